seg7_scan_ctrl: RTL

- Time-multiplexed scan controller for the 4-digit 7-segment display.
- Drives the select input of the existing 4:1 byte MUX and reads back the selected byte.
- Decodes that byte to segment patterns and strobes one digit anode at a time, with a blanking gap between digits to prevent ghosting.
- Sits between the MUX output and the display pins.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_hex_decode.sv | 20 ++
 rtl/seg7_scan_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan path: FSM encoding,
// the all-off segment pattern and the active-low hex glyph table.
package seg7_pkg;

   typedef enum logic [1:0] {
      ST_SELECT  = 2'd0,
      ST_LATCH   = 2'd1,
      ST_DISPLAY = 2'd2,
      ST_BLANK   = 2'd3
   } state_t;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // {dp,g,f,e,d,c,b,a}, active-low, dp off in every entry.
   localparam logic [7:0] HEX_SEG [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0,
      8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83,
      8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low segment pattern, with decimal point
// and a whole-digit blank override.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] seg
);

   always_comb begin
      seg    = HEX_SEG[nibble];
      seg[7] = ~dp;
      if (blank) begin
         seg = SEG_OFF;
      end
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit time-multiplexed 7-segment scan controller (SELECT/LATCH/DISPLAY/BLANK).
// Optional leading-zero blanking is compiled in with SEG7_SCAN_LZB_EN.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int DWELL_CYC = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   output logic [1:0] o_ctrl,
   output logic [3:0] o_an,
   output logic [7:0] o_seg,
   output logic       o_frame
);

   localparam int CW = cnt_width(DWELL_CYC, BLANK_CYC);
   localparam bit HAS_BLANK = (BLANK_CYC > 0);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
   localparam logic [CW-1:0] DWELL_PRE  = CW'(DWELL_CYC - 2);
   localparam logic [CW-1:0] BLANK_LAST = CW'(HAS_BLANK ? BLANK_CYC - 1 : 0);
   localparam logic [CW-1:0] BLANK_PRE  = CW'(BLANK_CYC - 2);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [7:0]    dec_seg;
   logic [7:0]    latch_seg;
   logic          unused_data;

   assign unused_data = &{1'b0, i_data[7:6]};

   seg7_hex_decode u_dec (
      .nibble (i_data[3:0]),
      .dp     (i_data[4]),
      .blank  (i_data[5]),
      .seg    (dec_seg)
   );

`ifdef SEG7_SCAN_LZB_EN
   logic lzb_flag;
   logic lzb_hit;
   logic advance;

   assign advance = HAS_BLANK ? (state == ST_BLANK && cnt == BLANK_LAST)
                              : (state == ST_DISPLAY && cnt == DWELL_LAST);
   // Digit 0 is never suppressed, so a value of zero still shows a single 0.
   assign lzb_hit = lzb_flag && (i_data[3:0] == 4'd0) && (o_ctrl != 2'd0) && !i_data[5];
   assign latch_seg = lzb_hit ? {~i_data[4], 7'h7F} : dec_seg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lzb_flag <= 1'b1;
      end else if (state == ST_LATCH && i_data[3:0] != 4'd0) begin
         lzb_flag <= 1'b0;
      end else if (advance && o_ctrl == 2'd0) begin
         lzb_flag <= 1'b1;
      end
   end
`else
   assign latch_seg = dec_seg;
`endif

   // o_frame is registered one cycle early so it is high during the final
   // cycle of digit 0, the same cycle the advance back to digit 3 happens.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= ST_SELECT;
         cnt     <= '0;
         o_ctrl  <= 2'b11;
         o_an    <= 4'hF;
         o_seg   <= SEG_OFF;
         o_frame <= 1'b0;
      end else begin
         o_frame <= 1'b0;
         case (state)
            ST_SELECT: begin
               state <= ST_LATCH;
            end
            ST_LATCH: begin
               o_seg   <= latch_seg;
               o_an    <= ~(4'b0001 << o_ctrl);
               cnt     <= '0;
               state   <= ST_DISPLAY;
               o_frame <= !HAS_BLANK && (DWELL_CYC == 1) && (o_ctrl == 2'd0);
            end
            ST_DISPLAY: begin
               if (cnt == DWELL_LAST) begin
                  o_an  <= 4'hF;
                  o_seg <= SEG_OFF;
                  cnt   <= '0;
                  if (HAS_BLANK) begin
                     state   <= ST_BLANK;
                     o_frame <= (BLANK_CYC == 1) && (o_ctrl == 2'd0);
                  end else begin
                     o_ctrl <= o_ctrl - 2'd1;
                     state  <= ST_SELECT;
                  end
               end else begin
                  cnt     <= cnt + 1'b1;
                  o_frame <= !HAS_BLANK && (cnt == DWELL_PRE) && (o_ctrl == 2'd0);
               end
            end
            ST_BLANK: begin
               if (cnt == BLANK_LAST) begin
                  o_ctrl <= o_ctrl - 2'd1;
                  cnt    <= '0;
                  state  <= ST_SELECT;
               end else begin
                  cnt     <= cnt + 1'b1;
                  o_frame <= (cnt == BLANK_PRE) && (o_ctrl == 2'd0);
               end
            end
            default: begin
               state <= ST_SELECT;
            end
         endcase
      end
   end

endmodule
